// File: rtl/rr_switch_allocator_if.sv
// Switch allocator bus for one router output port.
//   master : request side (input ports / test driver) -- drives req, rout_port,
//            tail, out_ready; observes grant, grant_idx, busy, xfer.
//   slave  : the allocator -- samples requests, drives grant/grant_idx/busy/xfer.
// rout_port packs one PORT_W-bit output code per input, field i at [i*PORT_W +: PORT_W].
interface rr_switch_allocator_if #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_W    = 3,
    parameter int IDX_W     = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
);
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS*PORT_W-1:0] rout_port;
    logic [NUM_PORTS-1:0]        tail;
    logic                        out_ready;
    logic [NUM_PORTS-1:0]        grant;
    logic [IDX_W-1:0]            grant_idx;
    logic                        busy;
    logic                        xfer;

    modport master (
        output req, rout_port, tail, out_ready,
        input  grant, grant_idx, busy, xfer
    );

    modport slave (
        input  req, rout_port, tail, out_ready,
        output grant, grant_idx, busy, xfer
    );
endinterface

// File: rtl/rr_switch_allocator.sv
// Round-robin switch allocator for a single router output port.
// Inputs whose routing field equals PORT_ID compete; the winner is locked onto
// the output until its tail flit transfers (or its request drops), so packets
// never interleave. Grants are registered (one-cycle latency) and issued
// without regard to out_ready.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - rr_switch_allocator_if.slave: req/rout_port/tail/out_ready in,
//          grant/grant_idx/busy (registered) and xfer (combinational) out
module rr_switch_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_W    = 3,
    parameter int PORT_ID   = 0
) (
    input logic                  clk,
    input logic                  rst,
    rr_switch_allocator_if.slave bus
);
    localparam int IDX_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]             state;
    logic [NUM_PORTS-1:0]   grant_q;
    logic [IDX_W-1:0]       grant_idx_q;
    logic [IDX_W-1:0]       ptr;

    logic [NUM_PORTS-1:0]   elig;
    logic [2*NUM_PORTS-1:0] elig2;
    logic [NUM_PORTS-1:0]   rot;
    logic                   found;
    logic [IDX_W-1:0]       win;
    logic [IDX_W:0]         sum;
    logic                   xfer_c;
    logic                   release_c;

    // An input is eligible only if it requests this exact output code;
    // out-of-range codes simply never match.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_elig
        assign elig[i] = bus.req[i] &&
                         (bus.rout_port[i*PORT_W +: PORT_W] == PORT_W'(PORT_ID));
    end

    // Rotate eligibility so bit 0 corresponds to ptr; the lowest set bit of
    // the rotated vector is the round-robin winner, offset back by ptr.
    assign elig2 = {elig, elig};

    always_comb begin
        rot   = NUM_PORTS'(elig2 >> ptr);
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(NUM_PORTS))
                    sum = sum - (IDX_W+1)'(NUM_PORTS);
                win = sum[IDX_W-1:0];
            end
        end
    end

    assign xfer_c    = (state == LOCKED) && bus.req[grant_idx_q] && bus.out_ready;
    // Release on the tail transfer, or abort when the owner withdraws its request.
    assign release_c = (xfer_c && bus.tail[grant_idx_q]) || !bus.req[grant_idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state       <= LOCKED;
                        grant_q     <= NUM_PORTS'(1) << win;
                        grant_idx_q <= win;
                        ptr         <= (win == IDX_W'(NUM_PORTS-1)) ? '0 : win + 1'b1;
                    end
                end
                LOCKED: begin
                    // grant_idx is left as-is on release; it is only meaningful while busy.
                    if (release_c) begin
                        state   <= IDLE;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_idx = grant_idx_q;
    assign bus.busy      = (state == LOCKED);
    assign bus.xfer      = xfer_c;
endmodule

// File: tb/tb_rr_switch_allocator.sv
module tb_rr_switch_allocator;
    localparam int NP = 5;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   xfer_cnt;

    always #5 clk = ~clk;

    rr_switch_allocator_if #(.NUM_PORTS(NP), .PORT_W(PW)) bus ();

    rr_switch_allocator #(.NUM_PORTS(NP), .PORT_W(PW), .PORT_ID(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    localparam logic [NP*PW-1:0] ROUT_ME  = '0;   // every field == PORT_ID (0)
    localparam logic [NP*PW-1:0] ROUT_BAD = '1;   // every field == 7, matches nothing

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [NP-1:0] g, input logic b,
                             input logic x);
        chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
        chk({tag, ".busy"},  32'(bus.busy),  32'(b));
        chk({tag, ".xfer"},  32'(bus.xfer),  32'(x));
    endtask

    logic [NP-1:0] fair_g [9];
    logic          rdy_pat [5];

    initial begin
        fair_g = '{5'b00001, 5'b00000, 5'b00100, 5'b00000, 5'b10000,
                   5'b00000, 5'b00001, 5'b00000, 5'b00100};
        rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // ---- reset, with requests present: nothing may be granted ----
        rst = 1'b1;
        bus.req = 5'b11111; bus.rout_port = ROUT_ME; bus.tail = '0; bus.out_ready = 1'b1;
        step();
        chk_state("rst1", 5'b0, 1'b0, 1'b0);
        step();
        chk_state("rst2", 5'b0, 1'b0, 1'b0);
        chk("rst.idx", 32'(bus.grant_idx), 0);
        chk("rst.ptr", 32'(dut.ptr), 0);

        // ---- basic grant: req 00110 -> input 1 wins ----
        rst = 1'b0; bus.req = 5'b00110;
        step();
        chk_state("basic", 5'b00010, 1'b1, 1'b1);
        chk("basic.idx", 32'(bus.grant_idx), 1);
        chk("basic.ptr", 32'(dut.ptr), 2);

        // withdraw: abort releases, ptr unchanged
        bus.req = 5'b00000;
        #1;
        chk("basic.xfer_off", 32'(bus.xfer), 0);
        step();
        chk_state("abort1", 5'b0, 1'b0, 1'b0);
        chk("abort1.ptr", 32'(dut.ptr), 2);

        // ---- abort of input 2 ----
        bus.req = 5'b00100;
        step();
        chk_state("lock2", 5'b00100, 1'b1, 1'b1);
        chk("lock2.idx", 32'(bus.grant_idx), 2);
        bus.req = 5'b00000;
        step();
        chk_state("abort2", 5'b0, 1'b0, 1'b0);
        chk("abort2.ptr", 32'(dut.ptr), 3);

        // ---- mid-packet reset while input 3 is locked ----
        bus.req = 5'b01000;
        step();
        chk_state("lock3", 5'b01000, 1'b1, 1'b1);
        chk("lock3.ptr", 32'(dut.ptr), 4);
        rst = 1'b1;
        step();
        chk_state("midrst", 5'b0, 1'b0, 1'b0);
        chk("midrst.idx", 32'(bus.grant_idx), 0);
        chk("midrst.ptr", 32'(dut.ptr), 0);

        // ---- fairness: 0,2,4 with single-flit packets; starts at 0 since ptr==0 ----
        rst = 1'b0; bus.req = 5'b10101; bus.tail = 5'b11111; bus.out_ready = 1'b1;
        for (int s = 0; s < 9; s++) begin
            step();
            chk_state($sformatf("fair%0d", s), fair_g[s], fair_g[s] != '0, fair_g[s] != '0);
        end
        // input 2 holds the output; drop everything to release it
        bus.req = 5'b00000; bus.tail = '0;
        step();
        chk_state("fair.rel", 5'b0, 1'b0, 1'b0);
        chk("fair.ptr", 32'(dut.ptr), 3);

        // ---- packet lock: input 3, 4 flits, input 0 competing ----
        bus.req = 5'b01001; bus.out_ready = 1'b0;
        step();
        xfer_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            bus.out_ready = rdy_pat[c];
            bus.tail      = (c == 4) ? 5'b01000 : 5'b00000;
            bus.rout_port = (c == 1) ? ROUT_BAD : ROUT_ME;  // routing churn must not matter
            #1;
            chk($sformatf("lock.grant%0d", c), 32'(bus.grant), 32'(5'b01000));
            chk($sformatf("lock.idx%0d", c),   32'(bus.grant_idx), 3);
            chk($sformatf("lock.xfer%0d", c),  32'(bus.xfer), 32'(rdy_pat[c]));
            if (bus.xfer) xfer_cnt++;
            step();
        end
        chk("lock.xfer_cnt", 32'(xfer_cnt), 4);
        bus.req = 5'b00001; bus.tail = '0; bus.out_ready = 1'b1;
        #1;
        chk_state("lock.gap", 5'b0, 1'b0, 1'b0);
        step();
        chk_state("lock.next", 5'b00001, 1'b1, 1'b1);
        chk("lock.next.ptr", 32'(dut.ptr), 1);
        bus.req = 5'b00000;
        step();
        chk_state("lock.done", 5'b0, 1'b0, 1'b0);

        // ---- routing mismatch: nobody is eligible for 10 cycles ----
        bus.req = 5'b11111; bus.rout_port = ROUT_BAD; bus.tail = 5'b11111;
        for (int s = 0; s < 10; s++) begin
            step();
            chk_state($sformatf("mis%0d", s), 5'b0, 1'b0, 1'b0);
        end
        chk("mis.ptr", 32'(dut.ptr), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the bench always ends on its own.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
